fetch_redirect_ctrl: RTL and testbench
======================================

Name: fetch_redirect_ctrl

Overview:
- Sequences the front-end after an exception or ERET redirect.
- Registers the exception-unit redirect request, blocks new instruction fetches, and drains outstanding instruction-SRAM/icache requests, discarding their stale responses.
- Issues one redirect to the PC generator over a valid/ready handshake.
- Sits between the exception unit, the fetch stage and the instruction bus interface; replaces ad-hoc flush release on data_ok/stall.

Parameters:
- MAX_OUTSTANDING, 4, maximum in-flight instruction requests the bus interface accepts.
- CNT_W, 3, outstanding-counter width; must hold MAX_OUTSTANDING.
- RESET_PC, 32'hBFC00000, redirect_pc value after reset.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- exc_valid  in  1  exception/ERET redirect request from exception unit (single-cycle pulse)
- exc_pc  in  32  target PC (exception vector or EPC)
- exc_is_eret  in  1  request is ERET; qualifies exc_valid
- inst_req_fire  in  1  fetch request accepted by instruction bus this cycle
- inst_data_ok  in  1  instruction response returned this cycle
- redirect_ready  in  1  PC generator accepts redirect
- inst_req_allow  out  1  fetch may issue a request this cycle
- discard_resp  out  1  current inst_data_ok response is stale; fetch drops it
- flush_front  out  1  kill IF/ID contents
- redirect_valid  out  1  redirect request to PC generator
- redirect_pc  out  32  redirect target
- redirect_is_eret  out  1  redirect originated from ERET
- busy  out  1  controller not IDLE

Behaviour:
- States: IDLE, DRAIN, REDIRECT; state, counter, redirect_pc and redirect_is_eret are registered.
- Reset: state=IDLE, outstanding count=0, redirect_pc=RESET_PC, redirect_is_eret=0. All outputs are then: inst_req_allow=1, discard_resp=0, flush_front=0, redirect_valid=0, busy=0.
- Counter: count_next = count + inst_req_fire - inst_data_ok.
  - Simultaneous fire and data_ok: count unchanged.
  - inst_data_ok at count==0: ignored (no underflow).
  - inst_req_fire is counted in every state, including the exc_valid cycle.
- inst_req_allow = (state==IDLE) && (count < MAX_OUTSTANDING). At count==MAX_OUTSTANDING, allow is 0.
- IDLE:
  - exc_valid=1 latches exc_pc and exc_is_eret.
  - Next state is REDIRECT if count_next==0, else DRAIN.
- DRAIN:
  - flush_front=1, busy=1, discard_resp=inst_data_ok, inst_req_allow=0.
  - Go to REDIRECT when count_next==0, i.e. the last response arrives in this cycle.
- REDIRECT:
  - redirect_valid=1, flush_front=1, busy=1. Any inst_data_ok here is also discarded.
  - On redirect_ready=1, go to IDLE; flush_front=0 from the next cycle.
  - redirect_pc is stable while redirect_valid=1 and not ready.
- Latency: exc_valid in cycle T with count 0 gives redirect_valid in T+1. With N outstanding responses, redirect_valid follows the cycle of the Nth response.
- exc_valid in DRAIN or REDIRECT: ignored. The pipeline is already flushed, so this is legal only as an echo; no state change.
- Reset mid-operation: returns to IDLE immediately, count cleared, no redirect issued.

Optional Feature:
- FETCH_REDIRECT_PERF_EN defined:
  - Adds outputs perf_redirects (32 bits) and perf_drain_cycles (32 bits).
  - perf_redirects increments on each redirect_valid && redirect_ready.
  - perf_drain_cycles increments on each cycle in DRAIN.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports absent, no counter logic.

Test Plan:
- exc_valid=1, exc_pc=32'hBFC00380, count=0, redirect_ready=1 -> redirect_valid=1 and redirect_pc=BFC00380 in T+1, IDLE in T+2, flush_front=0 in T+2.
- Issue 3 fires, then exc_valid=1 with exc_pc=32'hBFC00200; data_ok in T+2, T+4, T+5 -> DRAIN T+1..T+5, discard_resp=1 on all three, redirect_valid in T+6, inst_req_allow=0 throughout.
- Issue 4 fires without responses -> inst_req_allow=0 at count 4; one data_ok -> allow=1 next cycle; simultaneous fire+data_ok keeps count at 4.
- ERET with exc_pc=32'h80001234, redirect_ready held 0 for 5 cycles -> redirect_valid, redirect_pc and redirect_is_eret=1 stable; second exc_valid during the wait is ignored.
- reset asserted in DRAIN with count=2 -> next cycle IDLE, count 0, redirect_pc=BFC00000, redirect_valid never asserted.
- With FETCH_REDIRECT_PERF_EN defined, the scenario-2 run gives perf_redirects=1 and perf_drain_cycles=5.

Source files
------------

// File: rtl/fetch_redirect_ctrl.sv
// Front-end redirect sequencer: drains in-flight fetches after an exception/ERET, then hands one redirect to the PC generator.
// Optional FETCH_REDIRECT_PERF_EN adds redirect and drain-cycle performance counters.
module fetch_redirect_ctrl #(
  parameter int          MAX_OUTSTANDING = 4,
  parameter int          CNT_W           = 3,
  parameter logic [31:0] RESET_PC        = 32'hBFC00000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        exc_valid_i,
  input  logic [31:0] exc_pc_i,
  input  logic        exc_is_eret_i,
  input  logic        inst_req_fire_i,
  input  logic        inst_data_ok_i,
  input  logic        redirect_ready_i,
  output logic        inst_req_allow_o,
  output logic        discard_resp_o,
  output logic        flush_front_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        redirect_is_eret_o,
  output logic        busy_o
`ifdef FETCH_REDIRECT_PERF_EN
  ,
  output logic [31:0] perf_redirects_o,
  output logic [31:0] perf_drain_cycles_o
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      pc_q, pc_d;
  logic             eret_q, eret_d;

  // A response with nothing outstanding is spurious and must not wrap the counter.
  always_comb begin
    count_d = count_q;
    if (inst_req_fire_i && !inst_data_ok_i) begin
      count_d = count_q + 1'b1;
    end else if (!inst_req_fire_i && inst_data_ok_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    eret_d             = eret_q;
    inst_req_allow_o   = 1'b0;
    discard_resp_o     = 1'b0;
    flush_front_o      = 1'b0;
    redirect_valid_o   = 1'b0;
    busy_o             = 1'b0;
    unique case (state_q)
      IDLE: begin
        inst_req_allow_o = (count_q < MAX_CNT);
        if (exc_valid_i) begin
          pc_d    = exc_pc_i;
          eret_d  = exc_is_eret_i;
          state_d = (count_d == '0) ? REDIRECT : DRAIN;
        end
      end
      DRAIN: begin
        flush_front_o  = 1'b1;
        busy_o         = 1'b1;
        discard_resp_o = inst_data_ok_i;
        if (count_d == '0) begin
          state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        flush_front_o    = 1'b1;
        busy_o           = 1'b1;
        redirect_valid_o = 1'b1;
        discard_resp_o   = inst_data_ok_i;
        if (redirect_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      count_q <= '0;
      pc_q    <= RESET_PC;
      eret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      eret_q  <= eret_d;
    end
  end

  assign redirect_pc_o      = pc_q;
  assign redirect_is_eret_o = eret_q;

`ifdef FETCH_REDIRECT_PERF_EN
  logic [31:0] perf_redirects_q, perf_drain_cycles_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      perf_redirects_q    <= '0;
      perf_drain_cycles_q <= '0;
    end else begin
      if (redirect_valid_o && redirect_ready_i) begin
        perf_redirects_q <= perf_redirects_q + 32'd1;
      end
      if (state_q == DRAIN) begin
        perf_drain_cycles_q <= perf_drain_cycles_q + 32'd1;
      end
    end
  end

  assign perf_redirects_o    = perf_redirects_q;
  assign perf_drain_cycles_o = perf_drain_cycles_q;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: redirect handshakes are checked by a scoreboard monitor,
// per-cycle control outputs are checked inline against hand-derived values.
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exc, eret, fire, ok, rdy;
  logic [31:0] epc;
  logic        allow, discard, flush, rv, rv_eret, busy;
  logic [31:0] rv_pc;
`ifdef FETCH_REDIRECT_PERF_EN
  logic [31:0] perf_redir, perf_drain;
  logic [31:0] snap_redir, snap_drain;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0;

  typedef struct {
    logic [31:0] pc;
    logic        eret;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  fetch_redirect_ctrl dut (
    .clk_i              (clk),
    .reset_i            (rst),
    .exc_valid_i        (exc),
    .exc_pc_i           (epc),
    .exc_is_eret_i      (eret),
    .inst_req_fire_i    (fire),
    .inst_data_ok_i     (ok),
    .redirect_ready_i   (rdy),
    .inst_req_allow_o   (allow),
    .discard_resp_o     (discard),
    .flush_front_o      (flush),
    .redirect_valid_o   (rv),
    .redirect_pc_o      (rv_pc),
    .redirect_is_eret_o (rv_eret),
    .busy_o             (busy)
`ifdef FETCH_REDIRECT_PERF_EN
    ,
    .perf_redirects_o   (perf_redir),
    .perf_drain_cycles_o(perf_drain)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // One cycle of stimulus: drive just after the edge, leave time for outputs to settle.
  task automatic step(input logic f, input logic o, input logic e, input logic [31:0] p,
                      input logic er, input logic r);
    @(posedge clk);
    #1;
    fire = f; ok = o; exc = e; epc = p; eret = er; rdy = r;
    #1;
  endtask

  task automatic expect_redirect(input logic [31:0] p, input logic er, input int at);
    exp_t e;
    e.pc = p; e.eret = er; e.cyc = at;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rv && rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_redirect pc=%h at cycle %0d, none required", rv_pc, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("redir_pc", rv_pc, e.pc);
        chk("redir_eret", {31'd0, rv_eret}, {31'd0, e.eret});
        chk("redir_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    fire = 0; ok = 0; exc = 0; epc = '0; eret = 0; rdy = 0;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_allow", {31'd0, allow}, 32'd1);
    chk("rst_discard", {31'd0, discard}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_rv", {31'd0, rv}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pc", rv_pc, 32'hBFC00000);
    chk("rst_eret", {31'd0, rv_eret}, 32'd0);
    rst = 0;

    // Scenario 1: nothing outstanding, redirect one cycle after the exception.
    step(0, 0, 1, 32'hBFC00380, 0, 1);
    t0 = cyc;
    expect_redirect(32'hBFC00380, 1'b0, t0 + 1);
    chk("s1_exc_busy", {31'd0, busy}, 32'd0);
    chk("s1_exc_allow", {31'd0, allow}, 32'd1);
    step(0, 0, 0, 0, 0, 1);
    chk("s1_rv", {31'd0, rv}, 32'd1);
    chk("s1_flush", {31'd0, flush}, 32'd1);
    chk("s1_busy", {31'd0, busy}, 32'd1);
    step(0, 0, 0, 0, 0, 1);
    chk("s1_idle_busy", {31'd0, busy}, 32'd0);
    chk("s1_idle_flush", {31'd0, flush}, 32'd0);
    chk("s1_idle_allow", {31'd0, allow}, 32'd1);

    // Scenario 2: three in flight, responses at T+2, T+4, T+5.
    repeat (3) step(1, 0, 0, 0, 0, 1);
`ifdef FETCH_REDIRECT_PERF_EN
    snap_redir = perf_redir;
    snap_drain = perf_drain;
`endif
    step(0, 0, 1, 32'hBFC00200, 0, 1);
    t0 = cyc;
    expect_redirect(32'hBFC00200, 1'b0, t0 + 6);
    chk("s2_exc_allow", {31'd0, allow}, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      logic o;
      o = (i == 2) || (i == 4) || (i == 5);
      step(0, o, 0, 0, 0, 1);
      chk("s2_drain_busy", {31'd0, busy}, 32'd1);
      chk("s2_drain_flush", {31'd0, flush}, 32'd1);
      chk("s2_drain_allow", {31'd0, allow}, 32'd0);
      chk("s2_drain_discard", {31'd0, discard}, {31'd0, o});
      chk("s2_drain_rv", {31'd0, rv}, 32'd0);
    end
    step(0, 0, 0, 0, 0, 1);
    chk("s2_redir_rv", {31'd0, rv}, 32'd1);
    chk("s2_redir_allow", {31'd0, allow}, 32'd0);
    step(0, 0, 0, 0, 0, 1);
    chk("s2_idle_busy", {31'd0, busy}, 32'd0);
    chk("s2_idle_allow", {31'd0, allow}, 32'd1);
`ifdef FETCH_REDIRECT_PERF_EN
    chk("perf_redirects", perf_redir - snap_redir, 32'd1);
    chk("perf_drain_cycles", perf_drain - snap_drain, 32'd5);
`endif

    // Scenario 3: outstanding limit, simultaneous fire+ok, spurious ok at zero.
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 0, 1);
      chk("s3_fill_allow", {31'd0, allow}, 32'd1);
    end
    step(0, 0, 0, 0, 0, 1);
    chk("s3_max_allow", {31'd0, allow}, 32'd0);
    step(0, 1, 0, 0, 0, 1);
    chk("s3_ok_allow", {31'd0, allow}, 32'd0);
    step(1, 0, 0, 0, 0, 1);
    chk("s3_after_ok_allow", {31'd0, allow}, 32'd1);
    step(1, 1, 0, 0, 0, 1);
    chk("s3_both_allow", {31'd0, allow}, 32'd0);
    step(0, 1, 0, 0, 0, 1);
    chk("s3_still_max_allow", {31'd0, allow}, 32'd0);
    step(0, 1, 0, 0, 0, 1);
    chk("s3_three_allow", {31'd0, allow}, 32'd1);
    repeat (2) step(0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    chk("s3_spurious_discard", {31'd0, discard}, 32'd0);
    step(0, 0, 1, 32'h00001000, 0, 1);
    t0 = cyc;
    expect_redirect(32'h00001000, 1'b0, t0 + 1);
    step(0, 0, 0, 0, 0, 1);
    chk("s3_redir_rv", {31'd0, rv}, 32'd1);
    step(0, 0, 0, 0, 0, 1);
    chk("s3_idle_busy", {31'd0, busy}, 32'd0);

    // Scenario 4: ERET with back-pressure and an echoed exception.
    step(0, 0, 1, 32'h80001234, 1, 0);
    t0 = cyc;
    expect_redirect(32'h80001234, 1'b1, t0 + 6);
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, (i == 2), 32'hDEADBEEF, 0, 0);
      chk("s4_hold_rv", {31'd0, rv}, 32'd1);
      chk("s4_hold_pc", rv_pc, 32'h80001234);
      chk("s4_hold_eret", {31'd0, rv_eret}, 32'd1);
    end
    step(0, 0, 0, 0, 0, 1);
    chk("s4_release_rv", {31'd0, rv}, 32'd1);
    step(0, 0, 0, 0, 0, 1);
    chk("s4_idle_busy", {31'd0, busy}, 32'd0);

    // Scenario 5: reset while draining two outstanding requests.
    repeat (2) step(1, 0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h12345678, 1, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("s5_drain_busy", {31'd0, busy}, 32'd1);
    rst = 1;
    step(0, 0, 0, 0, 0, 1);
    chk("s5_rst_busy", {31'd0, busy}, 32'd0);
    chk("s5_rst_rv", {31'd0, rv}, 32'd0);
    chk("s5_rst_allow", {31'd0, allow}, 32'd1);
    chk("s5_rst_pc", rv_pc, 32'hBFC00000);
    chk("s5_rst_eret", {31'd0, rv_eret}, 32'd0);
    rst = 0;
    step(0, 0, 1, 32'h00002000, 0, 1);
    t0 = cyc;
    expect_redirect(32'h00002000, 1'b0, t0 + 1);
    step(0, 0, 0, 0, 0, 1);
    chk("s5_redir_rv", {31'd0, rv}, 32'd1);

    repeat (3) step(0, 0, 0, 0, 0, 1);
    chk("pending_redirects", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
